// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI byte sequencer: the sequencer state encoding
// and the default FIFO depth / start-timeout limit used by the top module.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int DEFAULT_DEPTH      = 8;  // entries per FIFO (power of 2)
  localparam int DEFAULT_WAIT_LIMIT = 4;  // cycles allowed for spi_en to rise

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_EN,
    BUSY,
    CAPTURE
  } seq_state_t;

endpackage : spi_pkg

// File: rtl/spi_sync_fifo.sv
// -----------------------------------------------------------------------------
// spi_sync_fifo
// Single-clock byte FIFO with count-based full/empty flags.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push       - write request; ignored while full (even with a same-cycle pop)
//   push_data  - byte to write
//   pop        - read request; ignored while empty
//   head       - byte at the read pointer (0 while empty)
//   full/empty - occupancy flags
// -----------------------------------------------------------------------------
module spi_sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Forcing 0 while empty keeps the head defined straight out of reset.
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; occupancy is tracked by count, so stale
  // contents are never observable and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule : spi_sync_fifo

// File: rtl/spi_byte_sequencer.sv
// -----------------------------------------------------------------------------
// spi_byte_sequencer
// Feeds bytes from a TX FIFO to a downstream SPI byte engine one at a time and
// collects the engine's received bytes into an RX FIFO.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   tx_data/valid/ready   - byte input stream into the TX FIFO
//   rx_data/valid/ready   - byte output stream from the RX FIFO
//   spi_data_in           - byte presented to the engine (held for the transfer)
//   spi_start             - one-cycle start pulse to the engine
//   spi_en                - engine transfer-active indication
//   spi_data_out          - byte received by the engine
//   busy                  - transfer in progress or TX bytes pending
//   err, err_clr          - sticky start-timeout flag and its clear
// -----------------------------------------------------------------------------
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] spi_data_in,
  output logic       spi_start,
  input  logic       spi_en,
  input  logic [7:0] spi_data_out,
  output logic       busy,
  output logic       err,
  input  logic       err_clr
);

  localparam int WCW = $clog2(WAIT_LIMIT + 1);

  seq_state_t     state;
  logic           spi_en_q;
  logic [WCW-1:0] wait_cnt;

  logic [7:0] tx_head;
  logic       tx_full;
  logic       tx_empty;
  logic       rx_full;
  logic       rx_empty;
  logic       tx_pop;
  logic       rx_push;

  assign tx_ready = ~tx_full;
  assign rx_valid = ~rx_empty;
  assign busy     = (state != IDLE) | ~tx_empty;

  // A byte is only launched when its reply is guaranteed an RX slot; nothing
  // else pushes RX between launch and CAPTURE, so the CAPTURE push never drops.
  assign tx_pop  = (state == IDLE) & ~tx_empty & ~rx_full;
  assign rx_push = (state == CAPTURE);

  spi_sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  spi_sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (spi_data_out),
    .pop       (rx_ready),
    .head      (rx_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      spi_start   <= 1'b0;
      spi_data_in <= 8'h00;
      spi_en_q    <= 1'b0;
      wait_cnt    <= '0;
      err         <= 1'b0;
    end else begin
      spi_en_q <= spi_en;
      // NOTE: the clear is written first so a timeout set later in this block
      // overrides it; with non-blocking assignments the last one wins.
      if (err_clr) err <= 1'b0;

      case (state)
        IDLE: begin
          // spi_en is deliberately not looked at here or in START.
          if (tx_pop) begin
            spi_data_in <= tx_head;
            spi_start   <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          spi_start <= 1'b0;
          wait_cnt  <= '0;
          state     <= WAIT_EN;
        end
        WAIT_EN: begin
          if (spi_en) begin
            state <= BUSY;
          end else if (wait_cnt == WCW'(WAIT_LIMIT - 1)) begin
            // Engine never answered: drop the byte without an RX push.
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        BUSY: begin
          if (spi_en_q && !spi_en) state <= CAPTURE;
        end
        CAPTURE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : spi_byte_sequencer

// File: doc/spi_byte_sequencer.md
SPI_BYTE_SEQUENCER -- requirements
Module: spi_byte_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entries per FIFO (power of 2, 2..64).
REQ-002 SHALL have parameter WAIT_LIMIT, default 4, meaning cycles allowed from start pulse to spi_en high.
REQ-003 SHALL have the ports below; one clock, and reset is asynchronous and active-high.
  clk  input  1  system clock, all logic on rising edge
  rst  input  1  asynchronous active-high reset
  tx_data  input  8  byte to transmit
  tx_valid  input  1  tx_data offered
  tx_ready  output  1  TX FIFO can accept
  rx_data  output  8  received byte (RX FIFO head)
  rx_valid  output  1  RX FIFO non-empty
  rx_ready  input  1  consumer takes rx_data
  spi_data_in  output  8  byte to the downstream SPI byte engine
  spi_start  output  1  one-cycle start pulse to the engine
  spi_en  input  1  engine transfer-active (chip-enable) indication
  spi_data_out  input  8  engine received byte
  busy  output  1  state != IDLE or TX FIFO non-empty
  err  output  1  sticky start-timeout flag
  err_clr  input  1  clears err

Function
REQ-004 SHALL buffer TX bytes in a DEPTH-entry FIFO; push = tx_valid & tx_ready; tx_ready = !tx_full; push while full is ignored even with a same-cycle pop.
REQ-005 SHALL buffer RX bytes in a DEPTH-entry FIFO; pop = rx_valid & rx_ready; rx_data = head, valid the cycle rx_valid is high; pop while empty is ignored.
REQ-006 SHALL allow a simultaneous push and pop on a non-full, non-empty FIFO, leaving the count unchanged; pointers wrap modulo DEPTH.
REQ-007 SHALL implement the FSM with states IDLE, START, WAIT_EN, BUSY and CAPTURE.
REQ-008 In IDLE, when TX is non-empty and RX has at least one free slot, the FSM SHALL pop the TX head into the spi_data_in register and go to START.
REQ-009 In START, spi_start SHALL be 1 for exactly that one cycle, then the FSM SHALL go to WAIT_EN.
REQ-010 spi_data_in SHALL stay constant from entry to START until the FSM returns to IDLE.
REQ-011 In WAIT_EN, the FSM SHALL go to BUSY when spi_en=1.
REQ-012 In WAIT_EN, after WAIT_LIMIT cycles without spi_en=1, the FSM SHALL set err, discard the byte (no RX push) and go to IDLE.
REQ-013 In BUSY, the FSM SHALL go to CAPTURE on the spi_en falling edge (registered spi_en_q=1, spi_en=0).
REQ-014 In CAPTURE, the FSM SHALL push spi_data_out into the RX FIFO and go to IDLE; the RX slot is guaranteed by REQ-008.
REQ-015 Nominal latency, TX push to spi_start, SHALL be 2 cycles when idle.
REQ-016 The minimum spacing between spi_start pulses SHALL be 2 cycles plus the engine transfer time.
REQ-017 err SHALL be set by a timeout and cleared by err_clr; a simultaneous set and clear SHALL leave err=1.
REQ-018 The sequencer SHALL keep transferring after err is set.
REQ-019 An spi_en rise in IDLE or START SHALL be ignored; no FSM action.

Reset
REQ-020 On rst, both FIFOs SHALL empty and the FSM SHALL enter IDLE.
REQ-021 On rst, spi_start=0, spi_data_in=0, err=0, busy=0, tx_ready=1, rx_valid=0 and rx_data=0.
REQ-022 Reset mid-transfer SHALL abort immediately; the in-flight byte is lost and no RX push occurs.
REQ-023 Reset deassertion SHALL need no synchronizer inside the block; the system drives rst synchronously deasserted.

Structure
REQ-024 Package spi_pkg SHALL hold the seq_state_t enum and the default DEPTH/WAIT_LIMIT constants.
REQ-025 Sub-module spi_sync_fifo (parameter DEPTH, width 8, count-based full/empty) SHALL be instantiated twice, for TX and RX.
REQ-026 The FSM, spi_en_q register, wait counter and err logic SHALL live in the top module.

Verification
REQ-027 Bench: push 0xA5 with the engine model echoing the inverted byte -> one spi_start pulse 2 cycles later, spi_data_in=0xA5 held, rx_data=0x5A and rx_valid=1 one cycle after CAPTURE.
REQ-028 Bench: push 8 bytes 0x01..0x08 back-to-back with rx_ready=1 -> tx_ready low after the 8th push if no pop yet, 8 starts in order, RX order 0x01..0x08 (echo model).
REQ-029 Bench: hold rx_ready=0 and push 9 bytes -> exactly 8 transfers, the 9th stays queued, busy=1; raise rx_ready for one pop -> 9th transfer starts.
REQ-030 Bench: engine never raises spi_en -> err=1 WAIT_LIMIT cycles after WAIT_EN entry, no RX push, next byte still started; err_clr -> err=0.
REQ-031 Bench: assert rst in BUSY -> all outputs at reset values the same cycle, FIFOs empty; after release, a push of 0x3C transfers normally.
REQ-032 Bench: with TX full, push and pop in the same cycle -> push rejected, count DEPTH-1; with TX count 3, push and pop -> count stays 3.
